sdes_key_schedule: RTL and testbench
====================================

Name: sdes_key_schedule

Overview:
Sequential S-DES subkey generator that sits directly downstream of the P10 key permutation (`permutation_p10`).
- Accepts a 10-bit key over a valid/ready handshake and applies P10 through an internal `permutation_p10` instance.
- Performs the LS-1 and LS-2 circular shifts on each 5-bit half, one per clock.
- Produces round subkeys K1 and K2 through P8, presented together over a valid/ready handshake to the round datapath.

Parameters:
- None. Key width (10) and subkey width (8) are fixed by S-DES.

Ports:
- `i_clk` input 1: sole clock, rising-edge.
- `i_rst_n` input 1: asynchronous, active-low reset.
- `i_key` input 10: raw key, bit 9 = S-DES key bit 1 (MSB-first numbering).
- `i_decrypt` input 1: sampled with `i_key`; 1 = present subkeys in decryption order.
- `i_key_valid` input 1: `i_key` / `i_decrypt` valid.
- `o_key_ready` output 1: block can accept a key.
- `o_k1` output 8: first-round subkey (K2 when decrypt latched).
- `o_k2` output 8: second-round subkey (K1 when decrypt latched).
- `o_keys_valid` output 1: `o_k1` / `o_k2` valid.
- `i_keys_ready` input 1: consumer accepts subkeys.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (`i_clk`, `i_rst_n`).
- Reset, asynchronous on `i_rst_n` low:
  - state = S_IDLE; internal 10-bit shift register = 0; decrypt flag = 0.
  - `o_k1` = 0, `o_k2` = 0, `o_keys_valid` = 0.
  - Reset mid-computation aborts; no partial subkeys are ever flagged valid.
- `o_key_ready` is combinational: 1 iff state == S_IDLE.
- FSM states: S_IDLE, S_LS1, S_LS2, S_DONE.
- S_IDLE:
  - On an edge with `i_key_valid` = 1: shift reg <= P10(`i_key`), decrypt flag <= `i_decrypt`, go to S_LS1.
  - Otherwise stay.
- S_LS1:
  - Shift reg <= LS1(reg).
  - K1 register <= P8(LS1(reg)).
  - Go to S_LS2.
- S_LS2:
  - Shift reg <= LS2(reg), i.e. cumulative rotate of 3.
  - K2 register <= P8(LS2(reg)).
  - `o_keys_valid` <= 1; go to S_DONE.
- S_DONE:
  - Hold `o_k1` / `o_k2` / `o_keys_valid` stable while `i_keys_ready` = 0.
  - On an edge with `i_keys_ready` = 1: `o_keys_valid` <= 0, go to S_IDLE.
- LSn: rotate-left by n applied independently to bits [9:5] and [4:0]; no carry between halves.
- P8 (S-DES positions 6 3 7 4 8 5 10 9, 1-indexed MSB-first):
  - o[7:0] = {r[4], r[7], r[3], r[6], r[2], r[5], r[0], r[1]}.
- Output mapping:
  - decrypt flag = 0: `o_k1` = K1, `o_k2` = K2.
  - decrypt flag = 1: `o_k1` = K2, `o_k2` = K1.
- Latency:
  - Accept edge = edge 1; `o_keys_valid` is high after edge 3.
  - Minimum 4 cycles per key.
- Inputs while busy: `i_key_valid` is ignored outside S_IDLE. The upstream must hold the key until it sees `o_key_ready`.
- Simultaneous events: consumer `i_keys_ready` may be held constantly high. S_DONE then lasts exactly one cycle.
- Stale data: `o_k1` / `o_k2` are don't-care when `o_keys_valid` = 0. They retain the last computed values until overwritten in S_LS1 / S_LS2.

Test Plan:
- Reset: assert `i_rst_n` = 0 mid-S_LS2 -> outputs 0, `o_keys_valid` 0, state S_IDLE, `o_key_ready` = 1 after release; the next key is processed normally.
- Encrypt vector: `i_key` = 10'b1010000010, `i_decrypt` = 0, `i_keys_ready` = 1 -> `o_keys_valid` high after edge 3; `o_k1` = 8'b10100100, `o_k2` = 8'b01000011.
- Decrypt vector: same key, `i_decrypt` = 1 -> `o_k1` = 8'b01000011, `o_k2` = 8'b10100100.
- Backpressure: `i_keys_ready` = 0 for 5 cycles after valid -> outputs stable, `o_key_ready` = 0; a new `i_key_valid` pulse during the stall is ignored. Release -> S_IDLE next edge.
- Edge keys:
  - `i_key` = 10'h000 -> K1 = K2 = 8'h00.
  - `i_key` = 10'h3FF -> K1 = K2 = 8'hFF.
- Back-to-back: `i_key_valid` held high with random keys, `i_keys_ready` = 1 -> one result every 4 cycles, all matching the reference model.

Source files
------------

// File: rtl/sdes_key_schedule.sv
// S-DES subkey generator: P10 on accept, then LS-1 / LS-2 one per clock, P8 into K1/K2.
// Subkeys are presented together over a valid/ready handshake, pre-swapped for decryption.

module permutation_p10 (
  input  logic [9:0] i_key,
  output logic [9:0] o_key
);
  // P10 = 3 5 2 7 4 10 1 9 8 6, key bit n lives at i_key[10-n]
  assign o_key = {i_key[7], i_key[5], i_key[8], i_key[3], i_key[6],
                  i_key[0], i_key[9], i_key[1], i_key[2], i_key[4]};
endmodule

// state  | meaning
// S_IDLE | waiting for a key, o_key_ready high
// S_LS1  | rotate halves by 1, capture K1
// S_LS2  | rotate halves by 2 more, capture K2, raise o_keys_valid
// S_DONE | hold subkeys until the consumer takes them
module sdes_key_schedule (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [9:0] i_key,
  input  logic       i_decrypt,
  input  logic       i_key_valid,
  output logic       o_key_ready,
  output logic [7:0] o_k1,
  output logic [7:0] o_k2,
  output logic       o_keys_valid,
  input  logic       i_keys_ready
);

  typedef enum logic [1:0] {S_IDLE, S_LS1, S_LS2, S_DONE} state_t;

  state_t     state_q;
  logic [9:0] shift_q;
  logic       dec_q;
  logic [7:0] k1_q;
  logic [7:0] k2_q;
  logic       valid_q;

  logic [9:0] p10_key;
  logic [9:0] rot1_d;
  logic [9:0] rot2_d;
  logic [7:0] p8_rot1_d;
  logic [7:0] p8_rot2_d;

  function automatic logic [9:0] ls1(input logic [9:0] r);
    return {r[8:5], r[9], r[3:0], r[4]};
  endfunction

  function automatic logic [9:0] ls2(input logic [9:0] r);
    return {r[7:5], r[9:8], r[2:0], r[4:3]};
  endfunction

  function automatic logic [7:0] p8(input logic [9:0] r);
    return {r[4], r[7], r[3], r[6], r[2], r[5], r[0], r[1]};
  endfunction

  permutation_p10 u_p10 (
    .i_key (i_key),
    .o_key (p10_key)
  );

  assign rot1_d    = ls1(shift_q);
  assign rot2_d    = ls2(shift_q);
  assign p8_rot1_d = p8(rot1_d);
  assign p8_rot2_d = p8(rot2_d);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      dec_q   <= 1'b0;
      k1_q    <= '0;
      k2_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_key_valid) begin
            shift_q <= p10_key;
            dec_q   <= i_decrypt;
            state_q <= S_LS1;
          end
        end
        S_LS1: begin
          shift_q <= rot1_d;
          // Write straight into the output slot so decryption needs no output mux.
          if (dec_q) k2_q <= p8_rot1_d;
          else       k1_q <= p8_rot1_d;
          state_q <= S_LS2;
        end
        S_LS2: begin
          shift_q <= rot2_d;
          if (dec_q) k1_q <= p8_rot2_d;
          else       k2_q <= p8_rot2_d;
          valid_q <= 1'b1;
          state_q <= S_DONE;
        end
        S_DONE: begin
          if (i_keys_ready) begin
            valid_q <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_key_ready  = (state_q == S_IDLE);
  assign o_k1         = k1_q;
  assign o_k2         = k2_q;
  assign o_keys_valid = valid_q;

endmodule

// File: tb/tb_sdes_key_schedule.sv
// Scoreboard bench for sdes_key_schedule: stimulus pushes expected subkeys,
// a negedge monitor compares whenever o_keys_valid is presented.

module tb_sdes_key_schedule;

  logic       clk;
  logic       rst_n;
  logic [9:0] key;
  logic       dec;
  logic       key_valid;
  logic       key_ready;
  logic [7:0] k1;
  logic [7:0] k2;
  logic       keys_valid;
  logic       keys_ready;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [15:0] exp;
    int          acc_cyc;
  } sb_entry_t;

  sb_entry_t sb[$];

  localparam int P10_POS[10] = '{3, 5, 2, 7, 4, 10, 1, 9, 8, 6};
  localparam int P8_POS[8]   = '{6, 3, 7, 4, 8, 5, 10, 9};

  sdes_key_schedule dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_key        (key),
    .i_decrypt    (dec),
    .i_key_valid  (key_valid),
    .o_key_ready  (key_ready),
    .o_k1         (k1),
    .o_k2         (k2),
    .o_keys_valid (keys_valid),
    .i_keys_ready (keys_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: S-DES key schedule written over 1-indexed bit lists.
  function automatic logic [15:0] ref_keys(input logic [9:0] k, input logic d);
    bit kb[10];
    bit pk[10];
    bit a[10];
    bit b[10];
    logic [7:0] s1;
    logic [7:0] s2;
    for (int i = 0; i < 10; i++) kb[i] = k[9-i];
    for (int i = 0; i < 10; i++) pk[i] = kb[P10_POS[i]-1];
    for (int h = 0; h < 2; h++)
      for (int i = 0; i < 5; i++) a[5*h+i] = pk[5*h+(i+1)%5];
    for (int h = 0; h < 2; h++)
      for (int i = 0; i < 5; i++) b[5*h+i] = a[5*h+(i+2)%5];
    for (int j = 0; j < 8; j++) begin
      s1[7-j] = a[P8_POS[j]-1];
      s2[7-j] = b[P8_POS[j]-1];
    end
    return d ? {s2, s1} : {s1, s2};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Present a key; push expectation on the cycle it is accepted.
  task automatic send(input logic [9:0] k, input logic d, input logic [15:0] exp, input bit hold);
    int n;
    bit ok;
    n = 0;
    ok = 0;
    key = k;
    dec = d;
    key_valid = 1'b1;
    while (n < 50) begin
      @(negedge clk);
      if (key_ready) begin
        ok = 1;
        break;
      end
      n++;
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL send_timeout key=%h never accepted", k);
    end else begin
      sb.push_back('{exp: exp, acc_cyc: cyc});
    end
    @(posedge clk);
    #1;
    if (!hold) key_valid = 1'b0;
  endtask

  bit valid_prev = 0;
  bit b2b_phase  = 0;
  int last_rise  = -1;

  always @(negedge clk) begin
    if (!rst_n) begin
      valid_prev = 0;
    end else begin
      if (keys_valid) begin
        check("busy_key_ready", 16'(key_ready), 16'h0000);
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_valid k1=%h k2=%h required=none", k1, k2);
        end else begin
          check("subkeys", {k1, k2}, sb[0].exp);
          if (!valid_prev) begin
            check("latency", 16'(cyc - sb[0].acc_cyc), 16'd3);
            if (b2b_phase && last_rise >= 0)
              check("b2b_spacing", 16'(cyc - last_rise), 16'd4);
            last_rise = cyc;
          end
          if (keys_ready) void'(sb.pop_front());
        end
      end
      valid_prev = keys_valid && !keys_ready;
    end
  end

  initial begin
    logic [9:0] rk;
    logic       rd;
    int         n;
    rst_n      = 1'b0;
    key        = '0;
    dec        = 1'b0;
    key_valid  = 1'b0;
    keys_ready = 1'b1;
    #1;
    check("reset_k1", 16'(k1), 16'h0000);
    check("reset_k2", 16'(k2), 16'h0000);
    check("reset_valid", 16'(keys_valid), 16'h0000);
    check("reset_key_ready", 16'(key_ready), 16'h0001);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    send(10'b1010000010, 1'b0, 16'hA443, 0);
    repeat (4) @(posedge clk);
    #1;
    send(10'b1010000010, 1'b1, 16'h43A4, 0);
    repeat (4) @(posedge clk);
    #1;

    // Abort mid-S_LS2: the accepted key must never produce a valid result.
    send(10'h2B7, 1'b0, ref_keys(10'h2B7, 1'b0), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("midreset_k1", 16'(k1), 16'h0000);
    check("midreset_k2", 16'(k2), 16'h0000);
    check("midreset_valid", 16'(keys_valid), 16'h0000);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("postreset_key_ready", 16'(key_ready), 16'h0001);
    @(posedge clk);
    #1;
    send(10'h2B7, 1'b0, ref_keys(10'h2B7, 1'b0), 0);
    repeat (4) @(posedge clk);
    #1;

    send(10'h000, 1'b0, 16'h0000, 0);
    repeat (4) @(posedge clk);
    #1;
    send(10'h3FF, 1'b1, 16'hFFFF, 0);
    repeat (4) @(posedge clk);
    #1;

    // Backpressure: hold result 5 cycles while a stray key pulse is offered.
    keys_ready = 1'b0;
    send(10'h1C5, 1'b0, ref_keys(10'h1C5, 1'b0), 0);
    n = 0;
    while (!keys_valid && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("stall_valid_seen", 16'(keys_valid), 16'h0001);
    repeat (5) begin
      key = 10'h0F3;
      dec = 1'b1;
      key_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    key_valid  = 1'b0;
    keys_ready = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("release_key_ready", 16'(key_ready), 16'h0001);
    check("release_valid", 16'(keys_valid), 16'h0000);

    // Back-to-back random keys with key_valid held high.
    b2b_phase = 1;
    last_rise = -1;
    for (int i = 0; i < 20; i++) begin
      rk = 10'($urandom_range(0, 1023));
      rd = 1'($urandom_range(0, 1));
      send(rk, rd, ref_keys(rk, rd), 1);
    end
    key_valid = 1'b0;

    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_empty", 16'(sb.size()), 16'h0000);
    b2b_phase = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
